control_sequencer: RTL and testbench

Hardwired control unit for the CPU datapath. It sequences fetch (T0–T2) and execute (T3–T7) steps for every instruction, and drives every datapath control strobe from a step counter plus the IR opcode. This is the unit that generates the strobe pattern the datapath consumes; until now the benches drove that pattern by hand. It sits beside `datapath`, with its outputs wired one-to-one to the datapath's control inputs.

---
 rtl/cpu_pkg.sv | 54 +++++
 rtl/control_sequencer_step_decoder.sv | 101 ++++++++++
 rtl/control_sequencer.sv | 105 ++++++++++
 tb/tb_control_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode values, sequencer states, strobe bundle.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } state_t;

  // Every datapath control strobe, one bit each.
  typedef struct packed {
    logic PCout, PCin, IncPC;
    logic MARin, MDRin, MDRout, Read, RAMin;
    logic IRin, Yin, ZLowIn, ZHighIn, ZLowout, ZHighout;
    logic HIin, LOin, HIout, LOout;
    logic GRA, GRB, GRC, BAout, Rin, Rout, Cout;
    logic InPortOut, OutPortIn, CONin;
    logic ADDsel;
  } strobes_t;

  function automatic logic is_mem(input logic [4:0] op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

  function automatic logic is_imm(input logic [4:0] op);
    return (op == OP_LDI) || (op == OP_ADDI);
  endfunction

  function automatic logic is_alu(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic is_single(input logic [4:0] op);
    return (op == OP_IN) || (op == OP_OUT) || (op == OP_MFHI) || (op == OP_MFLO);
  endfunction

  function automatic logic has_execute(input logic [4:0] op);
    return is_mem(op) || is_imm(op) || is_alu(op) || is_single(op);
  endfunction

endpackage

// File: rtl/control_sequencer_step_decoder.sv
// Combinational map from (state, opcode) to the datapath strobe bundle.
module step_decoder
  import cpu_pkg::*;
(
  input  state_t     state,
  input  logic [4:0] opcode,
  output strobes_t   strobes
);

  // Decode the strobes for the current step; anything not named stays 0.
  always_comb begin
    strobes = '0;
    case (state)
      T0: begin
        strobes.PCout  = 1'b1;
        strobes.MARin  = 1'b1;
        strobes.IncPC  = 1'b1;
        strobes.ZLowIn = 1'b1;
      end
      T1: begin
        strobes.ZLowout = 1'b1;
        strobes.PCin    = 1'b1;
        strobes.Read    = 1'b1;
        strobes.MDRin   = 1'b1;
      end
      T2: begin
        strobes.MDRout = 1'b1;
        strobes.IRin   = 1'b1;
      end
      T3: begin
        if (is_mem(opcode) || (opcode == OP_LDI)) begin
          strobes.GRB   = 1'b1;
          strobes.BAout = 1'b1;
          strobes.Yin   = 1'b1;
        end else if ((opcode == OP_ADDI) || is_alu(opcode)) begin
          strobes.GRB  = 1'b1;
          strobes.Rout = 1'b1;
          strobes.Yin  = 1'b1;
        end else if (opcode == OP_IN) begin
          strobes.InPortOut = 1'b1;
          strobes.GRA       = 1'b1;
          strobes.Rin       = 1'b1;
        end else if (opcode == OP_OUT) begin
          strobes.GRA       = 1'b1;
          strobes.Rout      = 1'b1;
          strobes.OutPortIn = 1'b1;
        end else if (opcode == OP_MFHI) begin
          strobes.HIout = 1'b1;
          strobes.GRA   = 1'b1;
          strobes.Rin   = 1'b1;
        end else if (opcode == OP_MFLO) begin
          strobes.LOout = 1'b1;
          strobes.GRA   = 1'b1;
          strobes.Rin   = 1'b1;
        end
      end
      T4: begin
        if (is_mem(opcode) || is_imm(opcode)) begin
          strobes.Cout   = 1'b1;
          strobes.ADDsel = 1'b1;
          strobes.ZLowIn = 1'b1;
        end else if (is_alu(opcode)) begin
          strobes.GRC    = 1'b1;
          strobes.Rout   = 1'b1;
          strobes.ZLowIn = 1'b1;
        end
      end
      T5: begin
        if (is_mem(opcode)) begin
          strobes.ZLowout = 1'b1;
          strobes.MARin   = 1'b1;
        end else if (is_imm(opcode) || is_alu(opcode)) begin
          strobes.ZLowout = 1'b1;
          strobes.GRA     = 1'b1;
          strobes.Rin     = 1'b1;
        end
      end
      T6: begin
        if (opcode == OP_LD) begin
          strobes.Read  = 1'b1;
          strobes.MDRin = 1'b1;
        end else if (opcode == OP_ST) begin
          strobes.GRA   = 1'b1;
          strobes.Rout  = 1'b1;
          strobes.MDRin = 1'b1;
        end
      end
      T7: begin
        if (opcode == OP_LD) begin
          strobes.MDRout = 1'b1;
          strobes.GRA    = 1'b1;
          strobes.Rin    = 1'b1;
        end else if (opcode == OP_ST) begin
          strobes.RAMin = 1'b1;
        end
      end
      default: strobes = '0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: steps fetch/execute and drives datapath strobes.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic           Clock,
  input  logic           Clear,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_rdy,
  input  logic           Stop,
  output logic           PCout, PCin, IncPC,
  output logic           MARin, MDRin, MDRout, Read, RAMin,
  output logic           IRin, Yin, ZLowIn, ZHighIn, ZLowout, ZHighout,
  output logic           HIin, LOin, HIout, LOout,
  output logic           GRA, GRB, GRC, BAout, Rin, Rout, Cout,
  output logic           InPortOut, OutPortIn, CONin,
  output logic           ADDsel,
  output logic           Run
);

  state_t     state;
  logic [4:0] op;
  strobes_t   strobes;
  state_t     done_state;

  // The opcode field is the top five bits of whatever width is presented.
  assign op = opcode[OPW-1 -: 5];

  // Where an instruction goes after its final step.
  assign done_state = Stop ? HALT : T0;

  // Step sequencing; memory steps wait on mem_rdy, HALT holds until Clear.
  always_ff @(posedge Clock) begin
    if (!Clear) begin
      state <= RST;
    end else begin
      case (state)
        RST: state <= T0;
        T0:  state <= T1;
        T1:  state <= mem_rdy ? T2 : T1;
        T2: begin
          if (op == OP_HALT)        state <= HALT;
          else if (has_execute(op)) state <= T3;
          else                      state <= done_state;
        end
        T3:  state <= (is_mem(op) || is_imm(op) || is_alu(op)) ? T4 : done_state;
        T4:  state <= T5;
        T5:  state <= is_mem(op) ? T6 : done_state;
        T6: begin
          if (op == OP_LD)      state <= mem_rdy ? T7 : T6;
          else if (op == OP_ST) state <= T7;
          else                  state <= done_state;
        end
        T7: begin
          if (op == OP_ST) state <= mem_rdy ? done_state : T7;
          else             state <= done_state;
        end
        HALT:    state <= HALT;
        default: state <= RST;
      endcase
    end
  end

  step_decoder u_step_decoder (
    .state   (state),
    .opcode  (op),
    .strobes (strobes)
  );

  // Fan the strobe bundle out to the individual datapath controls.
  always_comb begin
    PCout     = strobes.PCout;
    PCin      = strobes.PCin;
    IncPC     = strobes.IncPC;
    MARin     = strobes.MARin;
    MDRin     = strobes.MDRin;
    MDRout    = strobes.MDRout;
    Read      = strobes.Read;
    RAMin     = strobes.RAMin;
    IRin      = strobes.IRin;
    Yin       = strobes.Yin;
    ZLowIn    = strobes.ZLowIn;
    ZHighIn   = strobes.ZHighIn;
    ZLowout   = strobes.ZLowout;
    ZHighout  = strobes.ZHighout;
    HIin      = strobes.HIin;
    LOin      = strobes.LOin;
    HIout     = strobes.HIout;
    LOout     = strobes.LOout;
    GRA       = strobes.GRA;
    GRB       = strobes.GRB;
    GRC       = strobes.GRC;
    BAout     = strobes.BAout;
    Rin       = strobes.Rin;
    Rout      = strobes.Rout;
    Cout      = strobes.Cout;
    InPortOut = strobes.InPortOut;
    OutPortIn = strobes.OutPortIn;
    CONin     = strobes.CONin;
    ADDsel    = strobes.ADDsel;
    Run       = (state != RST) && (state != HALT);
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-instruction microprogram model, random mix.
module tb_control_sequencer;
  import cpu_pkg::*;

  logic       Clock = 1'b0;
  logic       Clear = 1'b0;
  logic [4:0] opcode = '0;
  logic       mem_rdy = 1'b0;
  logic       Stop = 1'b0;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, RAMin;
  logic IRin, Yin, ZLowIn, ZHighIn, ZLowout, ZHighout;
  logic HIin, LOin, HIout, LOout;
  logic GRA, GRB, GRC, BAout, Rin, Rout, Cout;
  logic InPortOut, OutPortIn, CONin, ADDsel, Run;

  int compared = 0;
  int mismatched = 0;
  int ram_cnt, out_cnt;

  typedef struct {
    strobes_t s;
    bit       wait_mem;
  } step_t;

  step_t    prog[$];
  strobes_t dut_s;

  always #5 Clock = ~Clock;

  control_sequencer #(.OPW(5)) dut (
    .Clock(Clock), .Clear(Clear), .opcode(opcode), .mem_rdy(mem_rdy), .Stop(Stop),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
    .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .RAMin(RAMin),
    .IRin(IRin), .Yin(Yin), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn),
    .ZLowout(ZLowout), .ZHighout(ZHighout),
    .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout),
    .GRA(GRA), .GRB(GRB), .GRC(GRC), .BAout(BAout), .Rin(Rin), .Rout(Rout), .Cout(Cout),
    .InPortOut(InPortOut), .OutPortIn(OutPortIn), .CONin(CONin),
    .ADDsel(ADDsel), .Run(Run)
  );

  always_comb begin
    dut_s = '0;
    dut_s.PCout = PCout;     dut_s.PCin = PCin;         dut_s.IncPC = IncPC;
    dut_s.MARin = MARin;     dut_s.MDRin = MDRin;       dut_s.MDRout = MDRout;
    dut_s.Read = Read;       dut_s.RAMin = RAMin;       dut_s.IRin = IRin;
    dut_s.Yin = Yin;         dut_s.ZLowIn = ZLowIn;     dut_s.ZHighIn = ZHighIn;
    dut_s.ZLowout = ZLowout; dut_s.ZHighout = ZHighout; dut_s.HIin = HIin;
    dut_s.LOin = LOin;       dut_s.HIout = HIout;       dut_s.LOout = LOout;
    dut_s.GRA = GRA;         dut_s.GRB = GRB;           dut_s.GRC = GRC;
    dut_s.BAout = BAout;     dut_s.Rin = Rin;           dut_s.Rout = Rout;
    dut_s.Cout = Cout;       dut_s.InPortOut = InPortOut;
    dut_s.OutPortIn = OutPortIn; dut_s.CONin = CONin;   dut_s.ADDsel = ADDsel;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void add_step(input strobes_t s, input bit w);
    step_t t;
    t.s = s;
    t.wait_mem = w;
    prog.push_back(t);
  endfunction

  // Whole-instruction microprogram: fetch, then the execute list for the opcode.
  function automatic void build_prog(input logic [4:0] op);
    strobes_t s;
    prog.delete();
    s = '0; s.PCout = 1; s.MARin = 1; s.IncPC = 1; s.ZLowIn = 1; add_step(s, 0);
    s = '0; s.ZLowout = 1; s.PCin = 1; s.Read = 1; s.MDRin = 1; add_step(s, 1);
    s = '0; s.MDRout = 1; s.IRin = 1; add_step(s, 0);
    case (op)
      OP_LD, OP_ST: begin
        s = '0; s.GRB = 1; s.BAout = 1; s.Yin = 1; add_step(s, 0);
        s = '0; s.Cout = 1; s.ADDsel = 1; s.ZLowIn = 1; add_step(s, 0);
        s = '0; s.ZLowout = 1; s.MARin = 1; add_step(s, 0);
        if (op == OP_LD) begin
          s = '0; s.Read = 1; s.MDRin = 1; add_step(s, 1);
          s = '0; s.MDRout = 1; s.GRA = 1; s.Rin = 1; add_step(s, 0);
        end else begin
          s = '0; s.GRA = 1; s.Rout = 1; s.MDRin = 1; add_step(s, 0);
          s = '0; s.RAMin = 1; add_step(s, 1);
        end
      end
      OP_LDI, OP_ADDI: begin
        s = '0; s.GRB = 1; s.Yin = 1;
        if (op == OP_LDI) s.BAout = 1; else s.Rout = 1;
        add_step(s, 0);
        s = '0; s.Cout = 1; s.ADDsel = 1; s.ZLowIn = 1; add_step(s, 0);
        s = '0; s.ZLowout = 1; s.GRA = 1; s.Rin = 1; add_step(s, 0);
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        s = '0; s.GRB = 1; s.Rout = 1; s.Yin = 1; add_step(s, 0);
        s = '0; s.GRC = 1; s.Rout = 1; s.ZLowIn = 1; add_step(s, 0);
        s = '0; s.ZLowout = 1; s.GRA = 1; s.Rin = 1; add_step(s, 0);
      end
      OP_IN:   begin s = '0; s.InPortOut = 1; s.GRA = 1; s.Rin = 1; add_step(s, 0); end
      OP_OUT:  begin s = '0; s.GRA = 1; s.Rout = 1; s.OutPortIn = 1; add_step(s, 0); end
      OP_MFHI: begin s = '0; s.HIout = 1; s.GRA = 1; s.Rin = 1; add_step(s, 0); end
      OP_MFLO: begin s = '0; s.LOout = 1; s.GRA = 1; s.Rin = 1; add_step(s, 0); end
      default: ;
    endcase
  endfunction

  // Run one instruction from T0; last_wait fixes stall cycles of the last wait
  // step (-1 random); abort_at leaves right after checking that step index.
  task automatic run_instr(input logic [4:0] op, input bit stop_final,
                           input int last_wait, input int abort_at);
    int lw;
    int waits;
    build_prog(op);
    lw = -1;
    foreach (prog[i]) if (prog[i].wait_mem) lw = i;
    ram_cnt = 0;
    out_cnt = 0;
    for (int k = 0; k < prog.size(); k++) begin
      if (!prog[k].wait_mem)            waits = 0;
      else if (k == lw && last_wait >= 0) waits = last_wait;
      else                              waits = $urandom_range(0, 3);
      for (int w = 0; w <= waits; w++) begin
        @(negedge Clock);
        opcode  = (k < 2) ? 5'($urandom_range(0, 31)) : op;
        mem_rdy = prog[k].wait_mem ? (w == waits) : 1'($urandom_range(0, 1));
        if (k == prog.size() - 1) Stop = (w == waits) ? stop_final : 1'b0;
        else                      Stop = 1'($urandom_range(0, 1));
        if (RAMin)     ram_cnt++;
        if (OutPortIn) out_cnt++;
        check($sformatf("op%b_step%0d", op, k), 32'({Run, dut_s}), 32'({1'b1, prog[k].s}));
        if (k == abort_at) return;
      end
    end
  endtask

  task automatic halt_hold(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      opcode  = 5'($urandom_range(0, 31));
      mem_rdy = 1'($urandom_range(0, 1));
      Stop    = 1'($urandom_range(0, 1));
      check("halt_hold", 32'({Run, dut_s}), 32'd0);
    end
  endtask

  // Clear low across two rising edges, starting from the current time.
  task automatic do_reset();
    Clear = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clock);
      check("reset_zero", 32'({Run, dut_s}), 32'd0);
    end
    Clear = 1'b1;
    Stop  = 1'b0;
  endtask

  task automatic run_and_settle(input logic [4:0] op, input bit stop_final);
    run_instr(op, stop_final, -1, -1);
    if (op == OP_HALT || stop_final) begin
      halt_hold(3);
      do_reset();
    end
  endtask

  logic [4:0] defined_ops[14] = '{OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
                                  OP_ADDI, OP_IN, OP_OUT, OP_MFHI, OP_MFLO, OP_NOP, OP_HALT};

  initial begin
    logic [4:0] rop;
    do_reset();

    // Reset in T4 of an add, then the fetch pattern after release.
    run_instr(OP_ADD, 1'b0, -1, 4);
    do_reset();

    run_instr(OP_LD, 1'b0, 0, -1);
    run_instr(OP_ST, 1'b0, 3, -1);
    check("st_ramin_cycles", 32'(ram_cnt), 32'd4);
    run_instr(OP_ADD, 1'b0, 0, -1);
    run_instr(5'b11111, 1'b0, 0, -1);
    run_instr(OP_NOP, 1'b0, -1, -1);

    run_instr(OP_OUT, 1'b1, -1, -1);
    check("out_pulse_count", 32'(out_cnt), 32'd1);
    halt_hold(5);
    do_reset();

    run_instr(OP_HALT, 1'b0, -1, -1);
    halt_hold(20);
    do_reset();

    foreach (defined_ops[i]) run_and_settle(defined_ops[i], 1'b0);

    for (int n = 0; n < 80; n++) begin
      rop = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) rop = defined_ops[$urandom_range(0, 13)];
      run_and_settle(rop, ($urandom_range(0, 9) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
